// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use stall and branch flush control for the ID->EX pipeline register
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_RegWrite,
    input  logic             id_MemRead,
    input  logic             branch_taken,
    output logic             stall_if,
    output logic             flush_if,
    output logic             clear_id,
    output logic             fwd_ex_1,
    output logic             fwd_mem_1,
    output logic             fwd_ex_2,
    output logic             fwd_mem_2,
    output logic [CNT_W-1:0] stall_cnt
);
    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [2:0]       fcnt, fcnt_nxt;
    logic [4:0]       ex_rd, mem_rd;
    logic             ex_wr, ex_ld, mem_wr;
    logic [CNT_W-1:0] cnt;
    logic             hit_ex_1, hit_ex_2, hit_mem_1, hit_mem_2;
    logic             lu, flushing;

    // dependency match of each ID source against the EX and MEM shadow destinations; x0 never matches
    always_comb begin
        hit_ex_1  = id_uses_rs1 & ex_wr  & (ex_rd  != 5'd0) & (ex_rd  == id_rs1);
        hit_ex_2  = id_uses_rs2 & ex_wr  & (ex_rd  != 5'd0) & (ex_rd  == id_rs2);
        hit_mem_1 = id_uses_rs1 & mem_wr & (mem_rd != 5'd0) & (mem_rd == id_rs1);
        hit_mem_2 = id_uses_rs2 & mem_wr & (mem_rd != 5'd0) & (mem_rd == id_rs2);
        lu        = id_valid & ex_ld & (hit_ex_1 | hit_ex_2);
    end

    // flush FSM state register; the burst length is loaded on entry to FLUSH
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fcnt  <= 3'd0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
        end
    end

    // flush FSM next state; a taken branch seen while already flushing is ignored
    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (state == IDLE) begin
            if (branch_taken && FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                fcnt_nxt  = 3'(FLUSH_CYCLES - 1);
            end
        end else begin
            fcnt_nxt = fcnt - 3'd1;
            if (fcnt == 3'd1) state_nxt = IDLE;
        end
    end

    // control outputs; flushing suppresses the load-use stall, reset forces a bubble and nothing else
    always_comb begin
        flushing  = !rst & ((state == FLUSH) | branch_taken);
        stall_if  = !rst & lu & !flushing;
        flush_if  = flushing;
        clear_id  = rst | flushing | stall_if;
        fwd_ex_1  = !rst & hit_ex_1 & !ex_ld;
        fwd_ex_2  = !rst & hit_ex_2 & !ex_ld;
        fwd_mem_1 = !rst & hit_mem_1 & !hit_ex_1;
        fwd_mem_2 = !rst & hit_mem_2 & !hit_ex_2;
        stall_cnt = rst ? '0 : cnt;
    end

    // shadow copies of EX/MEM destination info; a bubble enters EX whenever ID/EX is cleared or empty
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_rd  <= 5'd0;
            ex_wr  <= 1'b0;
            ex_ld  <= 1'b0;
            mem_rd <= 5'd0;
            mem_wr <= 1'b0;
        end else begin
            mem_rd <= ex_rd;
            mem_wr <= ex_wr;
            if (stall_if | flushing | !id_valid) begin
                ex_rd <= 5'd0;
                ex_wr <= 1'b0;
                ex_ld <= 1'b0;
            end else begin
                ex_rd <= id_rd;
                ex_wr <= id_RegWrite;
                ex_ld <= id_MemRead;
            end
        end
    end

    // saturating count of load-use stall cycles
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (stall_if && cnt != '1) cnt <= cnt + CNT_W'(1);
    end
endmodule
